chiplet_tx_arbiter: RTL and testbench
=====================================

Name: chiplet_tx_arbiter

Overview:
- Round-robin scheduler sharing the single master TX packetstream input of the chiplet system among NUM_REQ on-chip requesters.
- Selects one packet per cycle and registers it into a one-entry output stage, which drives i_master_tx_packetstream / _valid and sees o_master_tx_fsm_ready.
- Read responses (cmd 3'b010) get bounded priority, so responses are not blocked behind request traffic.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- PKT_WIDTH, 1076, packetstream width: {feature1[6], feature0[6], data[1024], addr[32], length[3], cmd[3], valid[1], mode[1]}, with mode at bit 0.
- PRIO_EN, 1, enables read-response priority.
- MAX_PRIO_STREAK, 4, maximum consecutive priority-override grants before a fair round-robin grant is forced.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- i_req_packetstream  in  NUM_REQ*PKT_WIDTH  flattened packets; requester k occupies [k*PKT_WIDTH +: PKT_WIDTH]
- i_req_valid  in  NUM_REQ  per-requester valid
- o_req_ready  out  NUM_REQ  one-hot accept; packet k is consumed when i_req_valid[k] && o_req_ready[k]
- o_packetstream  out  PKT_WIDTH  to the master TX FSM
- o_packetstream_valid  out  1  output holding register occupied
- i_fsm_ready  in  1  master TX FSM ready
- o_grant_id  out  $clog2(NUM_REQ)  source index of the packet in the output register
- o_prio_streak  out  $clog2(MAX_PRIO_STREAK+1)  current priority-streak counter

Behaviour:
- Clock and reset:
  - Single clock domain (clk). Reset is asynchronous and active-high (rst).
  - Reset values: o_packetstream = 0, o_packetstream_valid = 0, o_grant_id = 0, o_prio_streak = 0, rr_ptr = 0.
  - o_req_ready is combinational and is therefore 0 while rst is asserted.
- Output stage:
  - can_load = !o_packetstream_valid || i_fsm_ready.
  - A downstream transfer occurs when o_packetstream_valid && i_fsm_ready.
  - While o_packetstream_valid && !i_fsm_ready, o_packetstream and o_grant_id are held stable.
- Arbitration (combinational):
  - Arbitration runs only when can_load=1; otherwise o_req_ready = 0.
  - prio_vec[k] = i_req_valid[k] && pkt_k[4:2]==3'b010.
  - If PRIO_EN && |prio_vec && o_prio_streak < MAX_PRIO_STREAK, the candidate set is prio_vec; otherwise it is i_req_valid.
  - Winner = first set bit of the candidate set, searching rr_ptr, rr_ptr+1, ... with wrap modulo NUM_REQ. o_req_ready[winner] = 1; all other bits are 0.
  - No candidate: o_req_ready = 0.
- Grant (registered):
  - On a grant, rr_ptr <= (winner+1) mod NUM_REQ and o_grant_id <= winner.
  - If pkt_winner[1]==1: o_packetstream <= pkt_winner and o_packetstream_valid <= 1.
  - If pkt_winner[1]==0 (embedded invalid flag): the packet is consumed and discarded, and o_packetstream_valid <= 0 if the register is drained that cycle.
  - A load and a drain in the same cycle give back-to-back throughput of 1 packet/cycle. Latency from accept to o_packetstream_valid is 1 cycle.
  - No grant while draining: o_packetstream_valid <= 0.
- Priority streak:
  - Increments (saturating at MAX_PRIO_STREAK) on a grant chosen from prio_vec while some non-priority requester is also valid (an override).
  - Resets to 0 on a grant of a non-response packet, or when no non-priority requester is valid.
  - At saturation the next grant is plain round-robin over all valid requesters. If that grant is itself a response it still counts as fair, and the streak resets to 0.
- Boundary conditions:
  - All requesters valid with downstream stalled: no o_req_ready, and rr_ptr does not move.
  - Winner at index NUM_REQ-1: rr_ptr wraps to 0.
  - PRIO_EN=0: prio_vec is ignored and o_prio_streak stays 0.
  - rst asserted mid-operation: the output register is emptied immediately. The held packet is lost, and requesters retry because their valid remains high.

Test Plan:
- Reset/idle: hold rst 3 cycles, i_req_valid=0 -> all outputs 0; o_req_ready=0 during and after reset.
- Fair rotation: NUM_REQ=4, all valid with cmd 3'b001, i_fsm_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; o_packetstream_valid high continuously from cycle 1; each o_packetstream equals its source packet.
- Backpressure: i_fsm_ready=0 for 5 cycles with a packet held (addr 32'hFFDD0000) -> o_packetstream stable, o_req_ready=0; release -> drain and new load in the same cycle.
- Priority bound: req0 issues read responses (cmd 3'b010) every cycle, req1 issues a write (addr 32'h00000888) -> req0 granted 4 times (o_prio_streak 1..4), then req1 granted, streak back to 0.
- Discard: req2 sends a packet with bit1=0 -> o_req_ready[2] pulses once, o_packetstream_valid stays 0, rr_ptr=3.
- Mid-stream reset: assert rst while o_packetstream_valid=1 -> valid drops asynchronously; after release, granting restarts from requester 0.

Source files
------------

// File: rtl/chiplet_tx_arbiter.sv
// Round-robin TX arbiter: NUM_REQ requesters share one master TX packetstream through
// a one-entry output register; read responses get priority bounded by MAX_PRIO_STREAK.

module chiplet_tx_arbiter_lane (
    input  logic [2:0] i_cmd,
    input  logic       i_valid,
    output logic       o_prio,
    output logic       o_nonprio
);
    assign o_prio    = i_valid && (i_cmd == 3'b010);
    assign o_nonprio = i_valid && (i_cmd != 3'b010);
endmodule

module chiplet_tx_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int PKT_WIDTH       = 1076,
    parameter bit PRIO_EN         = 1'b1,
    parameter int MAX_PRIO_STREAK = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ*PKT_WIDTH-1:0]         i_req_packetstream,
    input  logic [NUM_REQ-1:0]                   i_req_valid,
    output logic [NUM_REQ-1:0]                   o_req_ready,
    output logic [PKT_WIDTH-1:0]                 o_packetstream,
    output logic                                 o_packetstream_valid,
    input  logic                                 i_fsm_ready,
    output logic [$clog2(NUM_REQ)-1:0]           o_grant_id,
    output logic [$clog2(MAX_PRIO_STREAK+1)-1:0] o_prio_streak
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int SW  = $clog2(MAX_PRIO_STREAK + 1);
    localparam logic [IDW:0]   NREQ       = (IDW+1)'(NUM_REQ);
    localparam logic [IDW-1:0] LAST_IDX   = IDW'(NUM_REQ - 1);
    localparam logic [SW-1:0]  STREAK_MAX = SW'(MAX_PRIO_STREAK);

    logic [NUM_REQ-1:0][PKT_WIDTH-1:0] w_pkt;
    logic [NUM_REQ-1:0]                w_prio;
    logic [NUM_REQ-1:0]                w_nonprio;
    logic [NUM_REQ-1:0]                w_cand;
    logic                              w_can_load;
    logic                              w_use_prio;
    logic                              w_has_np;
    logic                              w_found;
    logic                              w_grant;
    logic [IDW-1:0]                    w_winner;
    logic [IDW-1:0]                    w_rr_next;
    logic [PKT_WIDTH-1:0]              w_win_pkt;

    logic [PKT_WIDTH-1:0] r_pkt;
    logic                 r_valid;
    logic [IDW-1:0]       r_grant_id;
    logic [IDW-1:0]       r_rr_ptr;
    logic [SW-1:0]        r_streak;

    assign w_pkt = i_req_packetstream;

    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_lane
            chiplet_tx_arbiter_lane u_lane (
                .i_cmd     (w_pkt[g][4:2]),
                .i_valid   (i_req_valid[g]),
                .o_prio    (w_prio[g]),
                .o_nonprio (w_nonprio[g])
            );
        end
    endgenerate

    assign w_can_load = !r_valid || i_fsm_ready;
    assign w_has_np   = |w_nonprio;
    assign w_use_prio = PRIO_EN && (|w_prio) && (r_streak < STREAK_MAX);
    assign w_cand     = w_use_prio ? w_prio : i_req_valid;

    // Rotating priority search starting at rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        logic [IDW:0] v_idx;
        w_found  = 1'b0;
        w_winner = '0;
        v_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            v_idx = {1'b0, r_rr_ptr} + (IDW+1)'(i);
            if (v_idx >= NREQ)
                v_idx = v_idx - NREQ;
            if (!w_found && w_cand[v_idx[IDW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = v_idx[IDW-1:0];
            end
        end
    end

    assign w_grant     = !rst && w_can_load && w_found;
    assign o_req_ready = w_grant ? (NUM_REQ'(1) << w_winner) : '0;
    assign w_win_pkt   = w_pkt[w_winner];
    assign w_rr_next   = (w_winner == LAST_IDX) ? '0 : w_winner + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pkt      <= '0;
            r_valid    <= 1'b0;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
            r_streak   <= '0;
        end else begin
            if (w_grant) begin
                r_rr_ptr   <= w_rr_next;
                r_grant_id <= w_winner;
                // Packets with the embedded valid flag clear are consumed but dropped
                if (w_win_pkt[1]) begin
                    r_pkt   <= w_win_pkt;
                    r_valid <= 1'b1;
                end else begin
                    r_valid <= 1'b0;
                end
            end else if (i_fsm_ready) begin
                r_valid <= 1'b0;
            end

            if (w_grant)
                r_streak <= (w_use_prio && w_has_np) ? r_streak + SW'(1) : '0;
            else if (!w_has_np)
                r_streak <= '0;
        end
    end

    assign o_packetstream       = r_pkt;
    assign o_packetstream_valid = r_valid;
    assign o_grant_id           = r_grant_id;
    assign o_prio_streak        = r_streak;
endmodule

// File: tb/tb_chiplet_tx_arbiter.sv
// Directed table-driven bench for chiplet_tx_arbiter (NUM_REQ=4, default packet width).

module tb_chiplet_tx_arbiter;
    localparam int NR = 4;
    localparam int PW = 1076;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR*PW-1:0]  req_ps;
    logic [NR-1:0]     req_vld;
    logic [NR-1:0]     req_rdy;
    logic [PW-1:0]     ps;
    logic              ps_vld;
    logic              fsm_rdy;
    logic [1:0]        gid;
    logic [2:0]        streak;

    chiplet_tx_arbiter #(.NUM_REQ(NR), .PKT_WIDTH(PW), .PRIO_EN(1'b1), .MAX_PRIO_STREAK(4)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .i_req_packetstream   (req_ps),
        .i_req_valid          (req_vld),
        .o_req_ready          (req_rdy),
        .o_packetstream       (ps),
        .o_packetstream_valid (ps_vld),
        .i_fsm_ready          (fsm_rdy),
        .o_grant_id           (gid),
        .o_prio_streak        (streak)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  vld;
        logic [11:0] cmd;   // 3 bits per requester, requester 0 in the low bits
        logic [3:0]  pv;    // embedded packet valid flag per requester
        logic        fr;
        logic [31:0] addr;  // requester k uses addr + k
        logic [3:0]  e_rdy;
        logic        e_ov;
        logic [1:0]  e_gid;
        logic [2:0]  e_st;
    } vec_t;

    int checks = 0;
    int failures = 0;
    logic [PW-1:0] pkts [NR];
    logic [PW-1:0] exp_pkt;
    vec_t tbl [22];

    localparam logic [11:0] C_ALL1 = 12'b001_001_001_001;
    localparam logic [11:0] C_PRIO = 12'b000_000_001_010;

    function automatic vec_t V(logic [3:0] vld, logic [11:0] cmd, logic [3:0] pv, logic fr,
                               logic [31:0] addr, logic [3:0] e_rdy, logic e_ov,
                               logic [1:0] e_gid, logic [2:0] e_st);
        vec_t r;
        r.vld = vld; r.cmd = cmd; r.pv = pv; r.fr = fr; r.addr = addr;
        r.e_rdy = e_rdy; r.e_ov = e_ov; r.e_gid = e_gid; r.e_st = e_st;
        return r;
    endfunction

    function automatic logic [PW-1:0] mk(logic [2:0] cmd, logic [31:0] addr, logic vb, int k);
        logic [PW-1:0] p;
        p = '0;
        p[0]          = k[0];
        p[1]          = vb;
        p[4:2]        = cmd;
        p[39:8]       = addr;
        p[40 +: 32]   = 32'hA5A5_0000 | 32'(k);
        p[1075:1070]  = 6'(k + 1);
        return p;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_pkt(string nm, logic [PW-1:0] exp);
        checks++;
        if (ps !== exp) begin
            failures++;
            $display("FAIL %s: got addr=%0h cmd=%0h data=%0h expected addr=%0h cmd=%0h data=%0h",
                     nm, ps[39:8], ps[4:2], ps[71:40], exp[39:8], exp[4:2], exp[71:40]);
        end
    endtask

    task automatic apply(vec_t v);
        req_vld = v.vld;
        fsm_rdy = v.fr;
        for (int k = 0; k < NR; k++) begin
            pkts[k] = mk(v.cmd[k*3 +: 3], v.addr + 32'(k), v.pv[k], k);
            req_ps[k*PW +: PW] = pkts[k];
        end
    endtask

    initial begin
        // fair rotation, all requesters valid
        tbl[0]  = V(4'hF, C_ALL1, 4'hF, 1, 32'hA000_0000, 4'b0001, 1, 0, 0);
        tbl[1]  = V(4'hF, C_ALL1, 4'hF, 1, 32'hA100_0000, 4'b0010, 1, 1, 0);
        tbl[2]  = V(4'hF, C_ALL1, 4'hF, 1, 32'hA200_0000, 4'b0100, 1, 2, 0);
        tbl[3]  = V(4'hF, C_ALL1, 4'hF, 1, 32'hA300_0000, 4'b1000, 1, 3, 0);
        tbl[4]  = V(4'hF, C_ALL1, 4'hF, 1, 32'hFFDD_0000, 4'b0001, 1, 0, 0);
        // downstream stalled: packet held, no accepts, pointer frozen
        for (int i = 5; i < 10; i++)
            tbl[i] = V(4'hF, C_ALL1, 4'hF, 0, 32'hB000_0000 + 32'(i), 4'b0000, 1, 0, 0);
        tbl[10] = V(4'hF, C_ALL1, 4'hF, 1, 32'hC000_0000, 4'b0010, 1, 1, 0);
        // req0 read responses vs req1 write: 4 overrides then a fair grant
        tbl[11] = V(4'b0011, C_PRIO, 4'hF, 1, 32'h0000_0887, 4'b0001, 1, 0, 1);
        tbl[12] = V(4'b0011, C_PRIO, 4'hF, 1, 32'h0000_0887, 4'b0001, 1, 0, 2);
        tbl[13] = V(4'b0011, C_PRIO, 4'hF, 1, 32'h0000_0887, 4'b0001, 1, 0, 3);
        tbl[14] = V(4'b0011, C_PRIO, 4'hF, 1, 32'h0000_0887, 4'b0001, 1, 0, 4);
        tbl[15] = V(4'b0011, C_PRIO, 4'hF, 1, 32'h0000_0887, 4'b0010, 1, 1, 0);
        tbl[16] = V(4'b0011, C_PRIO, 4'hF, 1, 32'h0000_0887, 4'b0001, 1, 0, 1);
        // req2 embedded-invalid packet is consumed and dropped
        tbl[17] = V(4'b0100, C_ALL1, 4'b1011, 1, 32'hD000_0000, 4'b0100, 0, 2, 0);
        tbl[18] = V(4'hF, C_ALL1, 4'hF, 1, 32'hE000_0000, 4'b1000, 1, 3, 0);
        tbl[19] = V(4'h0, C_ALL1, 4'hF, 1, 32'hE100_0000, 4'b0000, 0, 3, 0);
        // lone response: no override, streak stays 0
        tbl[20] = V(4'b0001, C_PRIO, 4'hF, 1, 32'hE200_0000, 4'b0001, 1, 0, 0);
        tbl[21] = V(4'hF, C_ALL1, 4'hF, 1, 32'hE300_0000, 4'b0010, 1, 1, 0);

        rst = 1'b1; req_vld = '0; req_ps = '0; fsm_rdy = 1'b1; exp_pkt = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 2) req_vld = 4'hF;
            #1;
            chk("rst_ready", 64'(req_rdy), 0);
            chk("rst_ovalid", 64'(ps_vld), 0);
        end
        @(negedge clk);
        rst = 1'b0; req_vld = '0;
        #1;
        chk("idle_ready", 64'(req_rdy), 0);
        chk_pkt("idle_pkt", '0);
        chk("idle_gid", 64'(gid), 0);
        chk("idle_streak", 64'(streak), 0);

        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            apply(tbl[i]);
            #1;
            chk($sformatf("v%0d_ready", i), 64'(req_rdy), 64'(tbl[i].e_rdy));
            for (int k = 0; k < NR; k++)
                if (tbl[i].e_rdy[k] && tbl[i].pv[k]) exp_pkt = pkts[k];
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ovalid", i), 64'(ps_vld), 64'(tbl[i].e_ov));
            chk($sformatf("v%0d_gid", i), 64'(gid), 64'(tbl[i].e_gid));
            chk($sformatf("v%0d_streak", i), 64'(streak), 64'(tbl[i].e_st));
            if (tbl[i].e_ov) chk_pkt($sformatf("v%0d_pkt", i), exp_pkt);
        end

        // asynchronous reset while a packet is held
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_ovalid", 64'(ps_vld), 0);
        chk("mid_rst_ready", 64'(req_rdy), 0);
        chk_pkt("mid_rst_pkt", '0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(req_rdy), 64'(4'b0001));
        @(posedge clk);
        #1;
        chk("post_rst_gid", 64'(gid), 0);
        chk("post_rst_ovalid", 64'(ps_vld), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
